// File: rtl/apb_slave_if.sv
// ---------------------------------------------------------------------------
// apb_slave_if
//   APB bus bundle between a requester (master modport) and the apb_slave
//   completer (slave modport). Clock and reset are not part of the bundle.
//
//   Signals
//     psel     requester -> completer  completer selected
//     penable  requester -> completer  access phase
//     pwrite   requester -> completer  1 = write, 0 = read
//     paddr    requester -> completer  byte address, ADDR_WIDTH bits
//     pprot    requester -> completer  protection, bit 0 = privileged
//     pwdata   requester -> completer  write data, DATA_WIDTH bits
//     pstrb    requester -> completer  byte write strobes
//     pready   completer -> requester  transfer completes this cycle
//     prdata   completer -> requester  read data
//     pslverr  completer -> requester  transfer error
// ---------------------------------------------------------------------------
interface apb_slave_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [BYTES_PER_WORD-1:0] pstrb;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   APB completer fronting a small register file of MEM_DEPTH words of
//   DATA_WIDTH bits. A request is captured on its setup cycle, then the
//   completer spends WAIT_STATES access cycles with pready low before
//   completing. Writes honour byte strobes; reads return the whole word.
//   Out-of-range, unaligned, and unprivileged writes to word 0 complete
//   with pslverr and have no side effect.
//
//   Parameters
//     DATA_WIDTH      data width: 8, 16 or 32
//     ADDR_WIDTH      byte address width
//     MEM_DEPTH       number of words in the register file
//     WAIT_STATES     low-pready access cycles per transfer, 0..15
//     BYTES_PER_WORD  strobe width
//
//   Ports
//     pclk      clock, all state changes on its rising edge
//     preset_n  asynchronous active-low reset; clears FSM and register file
//     bus       apb_slave_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module apb_slave #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int MEM_DEPTH      = 64,
    parameter int WAIT_STATES    = 0,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic        pclk,
    input  logic        preset_n,
    apb_slave_if.slave  bus
);

    // Number of low address bits that select a byte inside a word.
    localparam int OFF_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [3:0]                wait_cnt_reg;

    // Request captured on the setup cycle; the bus may change afterwards.
    logic [ADDR_WIDTH-1:0]     paddr_reg;
    logic                      pwrite_reg;
    logic [2:0]                pprot_reg;
    logic [DATA_WIDTH-1:0]     pwdata_reg;
    logic [BYTES_PER_WORD-1:0] pstrb_reg;

    logic                      setup_req;
    logic                      access_done;
    logic                      capture_en;
    logic [ADDR_WIDTH-1:0]     word_idx;
    logic                      misaligned;
    logic                      out_of_range;
    logic                      priv_violation;
    logic                      access_err;
    logic                      wr_fire;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic [DATA_WIDTH-1:0]     mem_word [MEM_DEPTH];
    logic                      unused_prot;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    assign setup_req   = bus.psel && !bus.penable;
    assign access_done = (state_reg == ACCESS) && (wait_cnt_reg == 4'(WAIT_STATES));

    // A new request is taken from IDLE or, back-to-back, on the completing
    // edge of the current transfer.
    assign capture_en  = setup_req && ((state_reg == IDLE) || access_done);

    // -----------------------------------------------------------------------
    // Transfer FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // penable without a preceding setup cycle is ignored.
                    if (setup_req) begin
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    wait_cnt_reg <= '0;
                end
                ACCESS: begin
                    if (access_done) begin
                        state_reg <= setup_req ? SETUP : IDLE;
                    end else if (!bus.psel) begin
                        // Deselect before completion abandons the transfer.
                        state_reg <= IDLE;
                    end else if (bus.penable) begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pprot_reg  <= '0;
            pwdata_reg <= '0;
            pstrb_reg  <= '0;
        end else if (capture_en) begin
            paddr_reg  <= bus.paddr;
            pwrite_reg <= bus.pwrite;
            pprot_reg  <= bus.pprot;
            pwdata_reg <= bus.pwdata;
            pstrb_reg  <= bus.pstrb;
        end
    end

    // Only the privileged bit takes part in access checks.
    assign unused_prot = ^pprot_reg[2:1];

    // -----------------------------------------------------------------------
    // Address checks
    // -----------------------------------------------------------------------
    assign word_idx = paddr_reg >> OFF_W;

    generate
        if (OFF_W > 0) begin : g_align
            assign misaligned = |paddr_reg[OFF_W-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // Compare at 32 bits so MEM_DEPTH equal to the full index space is not
    // truncated to zero.
    assign out_of_range   = 32'(word_idx) >= 32'(MEM_DEPTH);
    // Word 0 is writable only by privileged requesters.
    assign priv_violation = pwrite_reg && !pprot_reg[0] && (word_idx == '0);
    assign access_err     = out_of_range || misaligned || priv_violation;

    // -----------------------------------------------------------------------
    // Register file: one async-cleared word per generate slice
    // -----------------------------------------------------------------------
    assign wr_fire = access_done && pwrite_reg && !access_err;

    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;
            logic                  word_sel;

            assign word_sel = wr_fire && (word_idx == ADDR_WIDTH'(gi));

            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    word_reg <= '0;
                end else if (word_sel) begin
                    for (int b = 0; b < BYTES_PER_WORD; b++) begin
                        if (pstrb_reg[b]) begin
                            word_reg[8*b +: 8] <= pwdata_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign mem_word[gi] = word_reg;
        end
    endgenerate

    // Read mux by comparison rather than direct indexing, so an
    // out-of-range index never addresses past the array.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (word_idx == ADDR_WIDTH'(i)) begin
                rd_word = mem_word[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Completer outputs
    // -----------------------------------------------------------------------
    assign bus.pready  = access_done;
    assign bus.pslverr = access_done && access_err;
    assign bus.prdata  = (access_done && !pwrite_reg && !access_err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
//   Two completers share one requester: dut0 with no wait states and dut1
//   with two. The requester's psel is routed to the completer picked by
//   'cur'; responses are muxed back the same way. Each issued transfer
//   pushes its expected response (computed from a plain array model of the
//   register file) into a queue; a monitor pops and compares on pready.
// ---------------------------------------------------------------------------
module tb_apb_slave;

    logic clk = 1'b0;
    logic preset_n = 1'b0;
    always #5 clk = ~clk;

    apb_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus0 ();
    apb_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus1 ();

    logic        m_psel    = 1'b0;
    logic        m_penable = 1'b0;
    logic        m_pwrite  = 1'b0;
    logic [9:0]  m_paddr   = '0;
    logic [2:0]  m_pprot   = '0;
    logic [31:0] m_pwdata  = '0;
    logic [3:0]  m_pstrb   = '0;
    int          cur       = 0;

    assign bus0.psel    = m_psel && (cur == 0);
    assign bus0.penable = m_penable;
    assign bus0.pwrite  = m_pwrite;
    assign bus0.paddr   = m_paddr;
    assign bus0.pprot   = m_pprot;
    assign bus0.pwdata  = m_pwdata;
    assign bus0.pstrb   = m_pstrb;
    assign bus1.psel    = m_psel && (cur == 1);
    assign bus1.penable = m_penable;
    assign bus1.pwrite  = m_pwrite;
    assign bus1.paddr   = m_paddr;
    assign bus1.pprot   = m_pprot;
    assign bus1.pwdata  = m_pwdata;
    assign bus1.pstrb   = m_pstrb;

    logic        s_pready;
    logic        s_pslverr;
    logic [31:0] s_prdata;
    assign s_pready  = (cur == 0) ? bus0.pready  : bus1.pready;
    assign s_pslverr = (cur == 0) ? bus0.pslverr : bus1.pslverr;
    assign s_prdata  = (cur == 0) ? bus0.prdata  : bus1.prdata;

    apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_DEPTH(64), .WAIT_STATES(0))
        dut0 (.pclk(clk), .preset_n(preset_n), .bus(bus0));
    apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_DEPTH(64), .WAIT_STATES(2))
        dut1 (.pclk(clk), .preset_n(preset_n), .bus(bus1));

    int ws_of [2] = '{0, 2};

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int txn_id     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference register file, one per completer.
    logic [31:0] ref_mem [2][64];

    typedef struct {
        int          id;
        int          dut;
        bit          wr;
        logic [9:0]  addr;
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                ref_mem[d][i] = '0;
    endtask

    // -----------------------------------------------------------------------
    // Monitor: counts low-pready cycles with psel & penable (this includes
    // the completer's SETUP cycle, so a transfer shows WAIT_STATES+1 of
    // them) and checks every completion against the queue head.
    // -----------------------------------------------------------------------
    int mon_waits = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_pready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pready: got pready=1 on dut%0d, expected no transfer pending", cur);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d dut%0d %s addr=0x%03h prdata=0x%08h pslverr=%0b waits=%0d",
                             e.id, e.dut, e.wr ? "WR" : "RD", e.addr, s_prdata, s_pslverr, mon_waits);
                    check("pslverr", 32'(s_pslverr), 32'(e.err));
                    check("prdata", s_prdata, e.rdata);
                    check("waits", 32'(mon_waits), 32'(e.waits));
                end
                mon_waits = 0;
            end else begin
                check("idle_pslverr", 32'(s_pslverr), 32'd0);
                check("idle_prdata", s_prdata, 32'd0);
                if (m_psel && m_penable) mon_waits++;
                else if (!m_psel)        mon_waits = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Requester. Called at negedge+1; returns at negedge+1 (or later).
    //   keep_sel  leave psel high so the next call is back-to-back
    //   abort_at  drop psel at this access-cycle count if not yet complete
    //   reset_at  assert preset_n at this access-cycle count
    // -----------------------------------------------------------------------
    task automatic xfer(input int d, input bit wr, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [2:0] prot, input bit keep_sel,
                        input int abort_at, input int reset_at, output int done_cyc);
        exp_t e;
        int   idx;
        bit   err;
        bit   got;
        cur = d;
        idx = int'(addr) / 4;
        err = (idx >= 64) || (int'(addr) % 4 != 0) || (wr && !prot[0] && idx == 0);
        e.id    = txn_id++;
        e.dut   = d;
        e.wr    = wr;
        e.addr  = addr;
        e.err   = err;
        e.rdata = (wr || err) ? 32'd0 : ref_mem[d][idx];
        e.waits = ws_of[d] + 1;
        exp_q.push_back(e);
        done_cyc = -1;

        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr;
        m_pwdata = data; m_pstrb = strb; m_pprot = prot;
        @(posedge clk);
        #1 m_penable = 1'b1;

        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            got = s_pready;
            if (k == reset_at) begin
                #1 preset_n = 1'b0;
                #1;
                check("rst_pready", 32'(s_pready), 32'd0);
                check("rst_pslverr", 32'(s_pslverr), 32'd0);
                check("rst_prdata", s_prdata, 32'd0);
                m_psel = 1'b0; m_penable = 1'b0;
                if (!got) void'(exp_q.pop_back());
                clear_model();
                return;
            end
            if (got) begin
                done_cyc = cyc;
                if (wr && !err)
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ref_mem[d][idx][8*b +: 8] = data[8*b +: 8];
                #1;
                if (!keep_sel) begin
                    m_psel = 1'b0; m_penable = 1'b0;
                    @(negedge clk);
                    #1;
                end
                return;
            end
            if (k == abort_at) begin
                #1 m_psel = 1'b0; m_penable = 1'b0;
                void'(exp_q.pop_back());
                @(negedge clk);
                #1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL pready_timeout: got no pready in 40 cycles on dut%0d addr 0x%03h, expected completion", d, addr);
        m_psel = 1'b0; m_penable = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #1 preset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int c1, c2, dc;
        int d, abort_at;
        bit wr, keep;
        logic [9:0] addr;

        clear_model();
        preset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pready0", 32'(bus0.pready), 32'd0);
        check("reset_pslverr0", 32'(bus0.pslverr), 32'd0);
        check("reset_prdata0", bus0.prdata, 32'd0);
        check("reset_pready1", 32'(bus1.pready), 32'd0);
        check("reset_pslverr1", 32'(bus1.pslverr), 32'd0);
        check("reset_prdata1", bus1.prdata, 32'd0);
        // Release and issue the first setup in the same cycle.
        #1 preset_n = 1'b1;

        // Full write/readback on both wait-state settings, then partial strobe.
        for (int dd = 0; dd < 2; dd++) begin
            xfer(dd, 1, 10'h07C, 32'h002A4C23, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 0, 10'h07C, 32'h0, 4'b0000, 3'b000, 0, -1, -1, dc);
            xfer(dd, 1, 10'h07C, 32'hAABBCCDD, 4'b0101, 3'b001, 0, -1, -1, dc);
            xfer(dd, 0, 10'h07C, 32'h0, 4'b1111, 3'b000, 0, -1, -1, dc);
        end

        // Error cases: out of range, unaligned, unprivileged word-0 write.
        for (int dd = 0; dd < 2; dd++) begin
            xfer(dd, 1, 10'h000, 32'h12345678, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 1, 10'h000, 32'hFFFFFFFF, 4'b1111, 3'b000, 0, -1, -1, dc);
            xfer(dd, 0, 10'h000, 32'h0, 4'b1111, 3'b000, 0, -1, -1, dc);
            xfer(dd, 0, 10'h100, 32'h0, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 1, 10'h100, 32'h55555555, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 0, 10'h07D, 32'h0, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 1, 10'h07D, 32'h66666666, 4'b1111, 3'b001, 0, -1, -1, dc);
            xfer(dd, 0, 10'h07C, 32'h0, 4'b1111, 3'b001, 0, -1, -1, dc);
        end

        // Back-to-back: second pready lands exactly WAIT_STATES+2 cycles later.
        for (int dd = 0; dd < 2; dd++) begin
            xfer(dd, 1, 10'h040, 32'hC0FFEE00 + 32'(dd), 4'b1111, 3'b001, 1, -1, -1, c1);
            xfer(dd, 0, 10'h040, 32'h0, 4'b1111, 3'b001, 0, -1, -1, c2);
            check("b2b_gap", 32'(c2 - c1), 32'(ws_of[dd] + 2));
        end

        // Abort on the wait-state completer, then confirm no write happened.
        xfer(1, 1, 10'h044, 32'h11112222, 4'b1111, 3'b001, 0, 2, -1, dc);
        xfer(1, 0, 10'h044, 32'h0, 4'b1111, 3'b001, 0, -1, -1, dc);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                               : 10'($urandom_range(0, 70) * 4);
            keep = ($urandom_range(0, 3) == 0);
            abort_at = -1;
            if (d == 1 && $urandom_range(0, 9) == 0) begin
                abort_at = int'($urandom_range(2, 3));
                keep = 1'b0;
            end
            xfer(d, wr, addr, $urandom, 4'($urandom), 3'($urandom), keep, abort_at, -1, dc);
        end

        // Reset in the second wait cycle of a write, then every word reads 0.
        xfer(1, 1, 10'h07C, 32'hDEADBEEF, 4'b1111, 3'b001, 0, -1, 3, dc);
        release_reset();
        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < 64; i++)
                xfer(dd, 0, 10'(i * 4), 32'h0, 4'b0000, 3'b001, 0, -1, -1, dc);

        // Reset during a completing read: pready and prdata must drop at once.
        xfer(0, 1, 10'h010, 32'h5A5A5A5A, 4'b1111, 3'b001, 0, -1, -1, dc);
        xfer(0, 0, 10'h010, 32'h0, 4'b1111, 3'b001, 0, -1, 2, dc);
        release_reset();
        xfer(0, 0, 10'h010, 32'h0, 4'b1111, 3'b001, 0, -1, -1, dc);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the PWDATA/PRDATA width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the PADDR width, as a byte address.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, meaning the number of DATA_WIDTH-bit words in the internal register file.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning the number of ACCESS cycles with PREADY held low, range 0..15.
REQ-005 SHALL have parameter BYTES_PER_WORD, default DATA_WIDTH/8, meaning the PSTRB width.
REQ-006 SHALL have port pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port preset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port psel, input, 1 bit: this completer is selected.
REQ-009 SHALL have port penable, input, 1 bit: access phase.
REQ-010 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port paddr, input, ADDR_WIDTH bits: byte address.
REQ-012 SHALL have port pprot, input, 3 bits: protection attributes; bit 0 = privileged.
REQ-013 SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port pstrb, input, BYTES_PER_WORD bits: byte write strobes.
REQ-015 SHALL have port pready, output, 1 bit: transfer completes this cycle.
REQ-016 SHALL have port prdata, output, DATA_WIDTH bits: read data.
REQ-017 SHALL have port pslverr, output, 1 bit: transfer error.

Function
REQ-018 SHALL implement a 3-state FSM: IDLE, SETUP, ACCESS.
REQ-019 SHALL move IDLE->SETUP when psel=1 and penable=0, capturing paddr, pwrite, pprot, pwdata and pstrb into internal registers.
REQ-020 SHALL move SETUP->ACCESS on the next edge unconditionally and clear the wait counter to 0.
REQ-021 SHALL, in ACCESS with psel=1, penable=1 and counter < WAIT_STATES, increment the counter and hold pready=0.
REQ-022 SHALL drive pready=1 combinationally when state=ACCESS and counter=WAIT_STATES; pready SHALL be 0 in every other state.
REQ-023 SHALL leave ACCESS on the completing edge (pready=1): go to SETUP if psel=1 and penable=0 (back-to-back, capturing the new request), otherwise go to IDLE.
REQ-024 SHALL treat psel=0 in ACCESS before completion as an abort: return to IDLE with no memory update and no pready pulse.
REQ-025 SHALL ignore penable=1 seen in IDLE without a preceding setup cycle, and SHALL stay in IDLE.
REQ-026 SHALL compute word index = captured paddr >> log2(BYTES_PER_WORD).
REQ-027 SHALL assert error when the word index is >= MEM_DEPTH, or when the captured paddr is not word-aligned, or when a write arrives with captured pprot[0]=0 and word index 0 (word 0 is a privileged-write-only register).
REQ-028 SHALL drive pslverr = pready AND error; pslverr SHALL be 0 whenever pready=0.
REQ-029 SHALL, on a completing write without error, update byte k of the addressed word only where captured pstrb[k]=1, on the same edge that pready=1 is sampled.
REQ-030 SHALL ignore pstrb on reads and SHALL return the full word.
REQ-031 SHALL drive prdata = addressed word when pready=1, pwrite=0 and there is no error; otherwise prdata SHALL be all-zero.
REQ-032 SHALL leave memory unmodified on any errored write.

Reset
REQ-033 SHALL, while preset_n=0, force state=IDLE and counter=0 immediately, independent of pclk, giving pready=0, pslverr=0 and prdata=0.
REQ-034 SHALL clear every register-file word to 0 on reset.
REQ-035 SHALL make reset asserted mid-ACCESS abandon the transfer with no write.
REQ-036 SHALL make the first setup cycle recognised after release be the first rising edge with preset_n=1.

Verification
REQ-037 Bench SHALL cover this case (WAIT_STATES=0): write paddr=0x7C, pwdata=0x002A4C23, pstrb=4'b1111, pprot=3'b001 -> pready=1 in the first ACCESS cycle, pslverr=0; a later read of 0x7C returns 0x002A4C23.
REQ-038 Bench SHALL cover this case (WAIT_STATES=2): read paddr=0x7C -> pready low for 2 ACCESS cycles, high on the 3rd, with prdata=0x002A4C23 only in that cycle.
REQ-039 Bench SHALL cover partial strobe: write 0xAABBCCDD with pstrb=4'b0101 over 0x002A4C23 -> readback 0x00BB4CDD.
REQ-040 Bench SHALL cover error cases: paddr=0x100 (index 64), paddr=0x7D (unaligned), and a write to 0x000 with pprot=3'b000 -> pslverr=1 with pready, memory unchanged, prdata=0.
REQ-041 Bench SHALL cover back-to-back transfers: write then read with psel held high and penable low for one cycle between them -> both complete, with no IDLE cycle between them.
REQ-042 Bench SHALL cover reset mid-operation: preset_n=0 in the second wait cycle of a write -> pready=0 at once; after release all words read 0.
